// File: rtl/wm_pkg.sv
// Shared types and defaults for the washing-cycle controller.
// State encoding, default sizes and phase index names.
package wm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_BILL  = 3'd4
  } state_e;

  localparam int DEF_NPROG   = 4;
  localparam int DEF_NPHASE  = 4;
  localparam int DEF_TW      = 8;
  localparam int DEF_BW      = 12;
  localparam int DEF_PW      = 12;
  localparam int DEF_TIMEOUT = 30;

  localparam int PH_FILL  = 0;
  localparam int PH_WASH  = 1;
  localparam int PH_RINSE = 2;
  localparam int PH_SPIN  = 3;

endpackage

// File: rtl/wm_cycle_ctrl_if.sv
// Button, program table and display bundle of the cycle controller.
// master drives buttons/config, slave is the controller.
interface wm_cycle_ctrl_if
  import wm_pkg::*;
#(
  parameter int NPROG  = DEF_NPROG,
  parameter int NPHASE = DEF_NPHASE,
  parameter int TW     = DEF_TW,
  parameter int BW     = DEF_BW,
  parameter int PW     = DEF_PW
);
  logic                       tick;
  logic                       start;
  logic                       pause;
  logic                       confirm;
  logic [$clog2(NPROG)-1:0]   prog_sel;
  logic [NPROG*NPHASE-1:0]    prog_mask;
  logic [NPHASE*TW-1:0]       phase_dur;
  logic [NPROG*PW-1:0]        prog_price;
  logic [PW-1:0]              fine;
  logic [BW-1:0]              bal_in;
  logic [2:0]                 state;
  logic [NPHASE-1:0]          phase_onehot;
  logic [TW-1:0]              remain;
  logic [BW-1:0]              bal_out;
  logic                       buzzer;
  logic                       fined;
  logic                       err;

  modport master (
    output tick, start, pause, confirm, prog_sel,
    output prog_mask, phase_dur, prog_price, fine, bal_in,
    input  state, phase_onehot, remain, bal_out,
    input  buzzer, fined, err
  );

  modport slave (
    input  tick, start, pause, confirm, prog_sel,
    input  prog_mask, phase_dur, prog_price, fine, bal_in,
    output state, phase_onehot, remain, bal_out,
    output buzzer, fined, err
  );
endinterface

// File: rtl/wm_next_phase.sv
// Priority finder for the next effective phase.
// from_start picks the lowest set bit, else lowest above cur.
module wm_next_phase #(
  parameter int NPHASE = 4,
  parameter int IW     = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
  input  logic [NPHASE-1:0] mask,
  input  logic [IW-1:0]     cur,
  input  logic              from_start,
  output logic [IW-1:0]     nxt,
  output logic              found
);

  // scan high to low so the lowest qualifying index wins
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NPHASE - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        nxt   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Programmable washing-cycle sequencer with pause,
// buzzer, overtime fine and final balance deduction.
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int NPROG   = DEF_NPROG,
  parameter int NPHASE  = DEF_NPHASE,
  parameter int TW      = DEF_TW,
  parameter int BW      = DEF_BW,
  parameter int PW      = DEF_PW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  wm_cycle_ctrl_if.slave bus
);

  localparam int SW = $clog2(NPROG);
  localparam int IW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [SW-1:0]  prog_q, prog_d;
  logic [BW-1:0]  bal_q, bal_d;
  logic [PW-1:0]  price_q, price_d;
  logic [IW-1:0]  phase_q, phase_d;
  logic [TW-1:0]  remain_q, remain_d;
  logic [BW-1:0]  bal_out_q, bal_out_d;
  logic           fined_q, fined_d;
  logic           err_q, err_d;
  logic [CW-1:0]  wait_q, wait_d;

  logic [NPROG*NPHASE-1:0] eff;
  logic [NPHASE-1:0]       mask;
  logic                    from_start;
  logic [IW-1:0]           nxt;
  logic                    found;
  logic [TW-1:0]           nxt_dur;
  logic [PW-1:0]           sel_price;
  logic signed [BW:0]      bal_x;
  logic signed [BW:0]      price_x;
  logic signed [BW:0]      bill_x;
  logic                    short;

  // effective phase = enabled and nonzero duration
  always_comb begin
    eff = '0;
    for (int p = 0; p < NPROG; p++) begin
      for (int i = 0; i < NPHASE; i++) begin
        eff[p*NPHASE+i] = bus.prog_mask[p*NPHASE+i] &&
                          (bus.phase_dur[i*TW +: TW] != '0);
      end
    end
  end

  assign from_start = (state_q == S_IDLE);
  assign mask = from_start ? eff[bus.prog_sel*NPHASE +: NPHASE]
                           : eff[prog_q*NPHASE +: NPHASE];

  wm_next_phase #(.NPHASE(NPHASE), .IW(IW)) u_next (
    .mask       (mask),
    .cur        (phase_q),
    .from_start (from_start),
    .nxt        (nxt),
    .found      (found)
  );

  // start acceptance and billing arithmetic at BW+1 bits
  always_comb begin
    nxt_dur   = bus.phase_dur[nxt*TW +: TW];
    sel_price = bus.prog_price[bus.prog_sel*PW +: PW];
    bal_x     = {bus.bal_in[BW-1], bus.bal_in};
    price_x   = signed'((BW+1)'(sel_price));
    short     = bal_x < price_x;
    bill_x    = signed'({bal_q[BW-1], bal_q})
              - signed'((BW+1)'(price_q))
              - (fined_q ? signed'((BW+1)'(bus.fine))
                         : signed'((BW+1)'(0)));
  end

  // next-state logic of the sequencer
  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    bal_d     = bal_q;
    price_d   = price_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    bal_out_d = bal_out_q;
    fined_d   = fined_q;
    err_d     = 1'b0;
    wait_d    = wait_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        prog_d  = bus.prog_sel;
        bal_d   = bus.bal_in;
        price_d = sel_price;
        if (short || !found) begin
          err_d = 1'b1;
        end else begin
          state_d  = S_RUN;
          phase_d  = nxt;
          remain_d = nxt_dur;
          fined_d  = 1'b0;
          wait_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (bus.tick) begin
          if (remain_q <= TW'(1)) begin
            if (found) begin
              phase_d  = nxt;
              remain_d = nxt_dur;
            end else begin
              state_d  = S_DONE;
              remain_d = '0;
              wait_d   = '0;
            end
          end else begin
            remain_d = remain_q - TW'(1);
          end
        end
      end
      S_PAUSE: if (bus.pause) state_d = S_RUN;
      S_DONE: begin
        if (bus.tick && (wait_q != CW'(TIMEOUT))) begin
          wait_d = wait_q + CW'(1);
          if (wait_q == CW'(TIMEOUT - 1)) fined_d = 1'b1;
        end
        if (bus.confirm) state_d = S_BILL;
      end
      S_BILL: begin
        bal_out_d = bill_x[BW-1:0];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      prog_q    <= '0;
      bal_q     <= '0;
      price_q   <= '0;
      phase_q   <= '0;
      remain_q  <= '0;
      bal_out_q <= '0;
      fined_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      bal_q     <= bal_d;
      price_q   <= price_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      bal_out_q <= bal_out_d;
      fined_q   <= fined_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.phase_onehot = ((state_q == S_RUN) || (state_q == S_PAUSE))
                          ? (NPHASE'(1) << phase_q) : '0;
  assign bus.remain       = remain_q;
  assign bus.bal_out      = bal_out_q;
  assign bus.buzzer       = (state_q == S_DONE);
  assign bus.fined        = fined_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl.
// Expected values are hand-computed from the program tables.
module tb_wm_cycle_ctrl;
  import wm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  wm_cycle_ctrl_if bus ();

  wm_cycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
    end
  endtask

  task automatic do_start(input logic [1:0] p, input logic [11:0] b);
    bus.prog_sel = p;
    bus.bal_in   = b;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
  endtask

  task automatic do_confirm();
    bus.confirm = 1'b1;
    cyc();
    bus.confirm = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", bus.state); end
    n_chk++; if (bus.phase_onehot !== 4'd0) begin n_fail++; $display("FAIL rst_onehot: got %b exp 0000", bus.phase_onehot); end
    n_chk++; if (bus.remain !== 8'd0) begin n_fail++; $display("FAIL rst_remain: got %0d exp 0", bus.remain); end
    n_chk++; if (bus.bal_out !== 12'd0) begin n_fail++; $display("FAIL rst_bal: got %0d exp 0", bus.bal_out); end
    n_chk++; if ({bus.buzzer, bus.fined, bus.err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {bus.buzzer, bus.fined, bus.err}); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_full_program();
    do_start(2'd1, 12'd100);
    n_chk++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL full_run: got %0d exp 1", bus.state); end
    n_chk++; if (bus.phase_onehot !== 4'b0001 || bus.remain !== 8'd3) begin n_fail++; $display("FAIL full_ph0: got %b/%0d exp 0001/3", bus.phase_onehot, bus.remain); end
    do_tick(3);
    n_chk++; if (bus.phase_onehot !== 4'b0010 || bus.remain !== 8'd2) begin n_fail++; $display("FAIL full_ph1: got %b/%0d exp 0010/2", bus.phase_onehot, bus.remain); end
    do_tick(2);
    n_chk++; if (bus.phase_onehot !== 4'b0100 || bus.remain !== 8'd4) begin n_fail++; $display("FAIL full_ph2: got %b/%0d exp 0100/4", bus.phase_onehot, bus.remain); end
    do_tick(4);
    n_chk++; if (bus.phase_onehot !== 4'b1000 || bus.remain !== 8'd5) begin n_fail++; $display("FAIL full_ph3: got %b/%0d exp 1000/5", bus.phase_onehot, bus.remain); end
    do_tick(4);
    n_chk++; if (bus.state !== 3'd1 || bus.remain !== 8'd1) begin n_fail++; $display("FAIL full_13: got %0d/%0d exp 1/1", bus.state, bus.remain); end
    do_tick(1);
    n_chk++; if (bus.state !== 3'd3 || bus.buzzer !== 1'b1 || bus.remain !== 8'd0 || bus.phase_onehot !== 4'd0) begin n_fail++; $display("FAIL full_done: got st %0d bz %b rem %0d oh %b exp 3 1 0 0000", bus.state, bus.buzzer, bus.remain, bus.phase_onehot); end
    do_confirm();
    n_chk++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL full_bill: got %0d exp 4", bus.state); end
    cyc();
    n_chk++; if (bus.state !== 3'd0 || bus.bal_out !== 12'd55 || bus.fined !== 1'b0) begin n_fail++; $display("FAIL full_bal: got st %0d bal %0d fined %b exp 0 55 0", bus.state, bus.bal_out, bus.fined); end
  endtask

  task automatic test_sparse_mask();
    logic bad;
    bad = 1'b0;
    bus.phase_dur = {8'd5, 8'd0, 8'd2, 8'd3};
    do_start(2'd2, 12'd100);
    n_chk++; if (bus.phase_onehot !== 4'b0001 || bus.remain !== 8'd3) begin n_fail++; $display("FAIL sparse_ph0: got %b/%0d exp 0001/3", bus.phase_onehot, bus.remain); end
    for (int i = 0; i < 3; i++) begin
      do_tick(1);
      if (bus.phase_onehot[3:1] !== 3'b000) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL sparse_onehot: got bad %b exp 0", bad); end
    n_chk++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL sparse_done: got %0d exp 3", bus.state); end
    do_confirm();
    cyc();
    n_chk++; if (bus.bal_out !== 12'd90) begin n_fail++; $display("FAIL sparse_bal: got %0d exp 90", bus.bal_out); end
    bus.phase_dur = {8'd5, 8'd4, 8'd2, 8'd3};
  endtask

  task automatic test_reject();
    do_start(2'd1, 12'd40);
    n_chk++; if (bus.err !== 1'b1 || bus.state !== 3'd0 || bus.bal_out !== 12'd90) begin n_fail++; $display("FAIL rej_short: got err %b st %0d bal %0d exp 1 0 90", bus.err, bus.state, bus.bal_out); end
    cyc();
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rej_pulse: got %b exp 0", bus.err); end
    do_start(2'd3, 12'd100);
    n_chk++; if (bus.err !== 1'b1 || bus.state !== 3'd0) begin n_fail++; $display("FAIL rej_nophase: got err %b st %0d exp 1 0", bus.err, bus.state); end
    cyc();
  endtask

  task automatic test_pause_and_reset();
    do_start(2'd1, 12'd100);
    do_tick(2);
    n_chk++; if (bus.remain !== 8'd1) begin n_fail++; $display("FAIL pause_pre: got %0d exp 1", bus.remain); end
    do_pause();
    n_chk++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL pause_enter: got %0d exp 2", bus.state); end
    do_tick(10);
    n_chk++; if (bus.state !== 3'd2 || bus.remain !== 8'd1 || bus.phase_onehot !== 4'b0001) begin n_fail++; $display("FAIL pause_hold: got %0d/%0d/%b exp 2/1/0001", bus.state, bus.remain, bus.phase_onehot); end
    do_pause();
    n_chk++; if (bus.state !== 3'd1 || bus.remain !== 8'd1) begin n_fail++; $display("FAIL pause_resume: got %0d/%0d exp 1/1", bus.state, bus.remain); end
    do_tick(1);
    n_chk++; if (bus.phase_onehot !== 4'b0010 || bus.remain !== 8'd2) begin n_fail++; $display("FAIL pause_expire: got %b/%0d exp 0010/2", bus.phase_onehot, bus.remain); end
    bus.pause = 1'b1;
    bus.tick  = 1'b1;
    cyc();
    bus.pause = 1'b0;
    bus.tick  = 1'b0;
    n_chk++; if (bus.state !== 3'd2 || bus.remain !== 8'd2) begin n_fail++; $display("FAIL pause_tick_same: got %0d/%0d exp 2/2", bus.state, bus.remain); end
    do_pause();
    do_tick(2);
    n_chk++; if (bus.phase_onehot !== 4'b0100 || bus.remain !== 8'd4) begin n_fail++; $display("FAIL pre_rst_ph2: got %b/%0d exp 0100/4", bus.phase_onehot, bus.remain); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (bus.state !== 3'd0 || bus.phase_onehot !== 4'd0 || bus.remain !== 8'd0 || bus.bal_out !== 12'd0 || {bus.buzzer, bus.fined, bus.err} !== 3'b000) begin n_fail++; $display("FAIL mid_rst: got st %0d oh %b rem %0d bal %0d exp all 0", bus.state, bus.phase_onehot, bus.remain, bus.bal_out); end
    #1 rst = 1'b1;
    cyc();
    do_start(2'd1, 12'd100);
    n_chk++; if (bus.state !== 3'd1 || bus.remain !== 8'd3) begin n_fail++; $display("FAIL post_rst_start: got %0d/%0d exp 1/3", bus.state, bus.remain); end
    rst = 1'b0;
    #1 rst = 1'b1;
    cyc();
  endtask

  task automatic test_overtime_fine();
    do_start(2'd0, 12'd50);
    do_tick(3);
    n_chk++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL fine_done: got %0d exp 3", bus.state); end
    do_tick(29);
    n_chk++; if (bus.fined !== 1'b0) begin n_fail++; $display("FAIL fine_early: got %b exp 0", bus.fined); end
    do_tick(1);
    n_chk++; if (bus.fined !== 1'b1 || bus.buzzer !== 1'b1) begin n_fail++; $display("FAIL fine_set: got %b/%b exp 1/1", bus.fined, bus.buzzer); end
    do_confirm();
    cyc();
    n_chk++; if (bus.bal_out !== 12'hFE9 || bus.state !== 3'd0) begin n_fail++; $display("FAIL fine_bal: got %h/%0d exp fe9/0", bus.bal_out, bus.state); end
  endtask

  task automatic test_back_to_back();
    do_start(2'd0, 12'd100);
    n_chk++; if (bus.fined !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %b exp 0", bus.fined); end
    do_tick(3);
    do_tick(29);
    bus.confirm = 1'b1;
    bus.tick    = 1'b1;
    cyc();
    bus.confirm = 1'b0;
    bus.tick    = 1'b0;
    n_chk++; if (bus.state !== 3'd4 || bus.fined !== 1'b1) begin n_fail++; $display("FAIL b2b_bill: got %0d/%b exp 4/1", bus.state, bus.fined); end
    cyc();
    n_chk++; if (bus.bal_out !== 12'd27) begin n_fail++; $display("FAIL b2b_bal: got %0d exp 27", bus.bal_out); end
    do_confirm();
    do_start(2'd1, 12'd100);
    n_chk++; if (bus.state !== 3'd1 || bus.fined !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got %0d/%b exp 1/0", bus.state, bus.fined); end
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.confirm    = 1'b0;
    bus.prog_sel   = 2'd0;
    bus.prog_mask  = 16'h05F1;
    bus.phase_dur  = {8'd5, 8'd4, 8'd2, 8'd3};
    bus.prog_price = {12'd0, 12'd10, 12'd45, 12'd45};
    bus.fine       = 12'd28;
    bus.bal_in     = 12'd0;
    test_reset();
    test_full_program();
    test_sparse_mask();
    test_reject();
    test_pause_and_reset();
    test_overtime_fine();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
